// File: rtl/fll_pkg.sv
// ---------------------------------------------------------------------------
// fll_pkg
// Shared types and helpers for the FLL frequency discriminator.
//   fll_state_t : window sequencer states (IDLE, GATE, DONE)
//   delta_w()   : width of the signed count difference for a given counter
//                 width (one extra bit so the difference of two unsigned
//                 CNT_W values always fits)
// ---------------------------------------------------------------------------
package fll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } fll_state_t;

    function automatic int delta_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/zc_schmitt_cnt.sv
// ---------------------------------------------------------------------------
// zc_schmitt_cnt
// One hysteresis-qualified positive zero-crossing detector plus a saturating
// event counter with a sticky overflow flag.
//   clk, reset_l : clock, asynchronous active-low reset
//   clk_en_i     : sample strobe; the detector only looks at strobed samples
//   clr_i        : clear count and overflow (window start); wins over counting
//   cnt_en_i     : counting window open
//   sample_i     : signed sample
//   cnt_nxt_o    : count value after this cycle (next-state view)
//   ovf_nxt_o    : overflow flag after this cycle (next-state view)
// The next-state views let the parent capture a window result on the same
// edge that counts the final strobe.
// ---------------------------------------------------------------------------
module zc_schmitt_cnt
    import fll_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 24,
    parameter int HYST   = 100
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic                     clk_en_i,
    input  logic                     clr_i,
    input  logic                     cnt_en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic        [CNT_W-1:0]  cnt_nxt_o,
    output logic                     ovf_nxt_o
);

    localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;
    localparam logic        [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic             neg_q;
    logic             neg_d;
    logic             event_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // Schmitt detector: arm on a low excursion, fire (and disarm) on a high one
    always_comb begin
        event_s = 1'b0;
        neg_d   = neg_q;
        if (clk_en_i) begin
            if (neg_q && (sample_i >= HYST_POS)) begin
                event_s = 1'b1;
                neg_d   = 1'b0;
            end else if (sample_i <= HYST_NEG) begin
                neg_d   = 1'b1;
            end else begin
                neg_d   = neg_q;
            end
        end else begin
            neg_d = neg_q;
        end
    end

    // Saturating counter; an event that would wrap sets the sticky overflow
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (cnt_en_i && event_s) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Detector flag and counter state
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            neg_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_nxt_o = cnt_d;
    assign ovf_nxt_o = ovf_d;

endmodule

// File: rtl/fll_freq_disc.sv
// ---------------------------------------------------------------------------
// fll_freq_disc
// Frequency discriminator for the FLL: counts qualified positive crossings of
// the input and of the NCO signal over a gate of gate_len sample strobes and
// reports count_gen - count_input at the end of each window.
//   clk, reset_l   : clock, asynchronous active-low reset
//   clk_en         : sample strobe
//   start          : request one window (ignored while busy)
//   continuous     : run windows back-to-back while high
//   gate_len       : window length in strobes (0 behaves as 1), latched at
//                    window start
//   signal_input   : signed input samples
//   signal_gen     : signed generator samples
//   delta          : signed count difference, holds the last result
//   delta_valid    : one-cycle pulse when delta updates
//   ovf            : {gen, input} counter saturated in the last window
//   lock           : LOCK_N consecutive in-tolerance windows seen
//   busy           : window sequencer in GATE or DONE
// ---------------------------------------------------------------------------
module fll_freq_disc
    import fll_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 24,
    parameter int GATE_W   = 32,
    parameter int HYST     = 100,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_N   = 4
) (
    input  logic                            clk,
    input  logic                            reset_l,
    input  logic                            clk_en,
    input  logic                            start,
    input  logic                            continuous,
    input  logic        [GATE_W-1:0]        gate_len,
    input  logic signed [DATA_W-1:0]        signal_input,
    input  logic signed [DATA_W-1:0]        signal_gen,
    output logic signed [delta_w(CNT_W)-1:0] delta,
    output logic                            delta_valid,
    output logic        [1:0]               ovf,
    output logic                            lock,
    output logic                            busy
);

    localparam int DW       = delta_w(CNT_W);
    localparam int STREAK_W = $clog2(LOCK_N + 1);

    fll_state_t             state_q;
    fll_state_t             state_d;
    logic [GATE_W-1:0]      gate_q;
    logic [GATE_W-1:0]      gate_d;
    logic                   clr_s;
    logic                   gate_open_s;
    logic                   done_fire_s;

    logic [CNT_W-1:0]       cnt_in_nxt_s;
    logic [CNT_W-1:0]       cnt_gen_nxt_s;
    logic                   ovf_in_nxt_s;
    logic                   ovf_gen_nxt_s;

    logic signed [DW-1:0]   delta_d;
    logic        [DW-1:0]   delta_mag_s;
    logic                   in_tol_s;
    logic [STREAK_W-1:0]    streak_q;
    logic [STREAK_W-1:0]    streak_d;

    logic signed [DW-1:0]   delta_q;
    logic                   delta_valid_q;
    logic [1:0]             ovf_q;
    logic                   lock_q;
    logic                   busy_q;

    zc_schmitt_cnt #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .HYST   (HYST)
    ) u_zc_input (
        .clk       (clk),
        .reset_l   (reset_l),
        .clk_en_i  (clk_en),
        .clr_i     (clr_s),
        .cnt_en_i  (gate_open_s),
        .sample_i  (signal_input),
        .cnt_nxt_o (cnt_in_nxt_s),
        .ovf_nxt_o (ovf_in_nxt_s)
    );

    zc_schmitt_cnt #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .HYST   (HYST)
    ) u_zc_gen (
        .clk       (clk),
        .reset_l   (reset_l),
        .clk_en_i  (clk_en),
        .clr_i     (clr_s),
        .cnt_en_i  (gate_open_s),
        .sample_i  (signal_gen),
        .cnt_nxt_o (cnt_gen_nxt_s),
        .ovf_nxt_o (ovf_gen_nxt_s)
    );

    // Window sequencer: next state plus window-boundary strobes
    always_comb begin
        state_d     = state_q;
        clr_s       = 1'b0;
        gate_open_s = 1'b0;
        done_fire_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = GATE;
                    clr_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GATE: begin
                gate_open_s = 1'b1;
                // Last strobe of the window: its crossing is still counted
                if (clk_en && (gate_q == GATE_W'(1))) begin
                    state_d     = DONE;
                    done_fire_s = 1'b1;
                end else begin
                    state_d = GATE;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d = GATE;
                    clr_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gate strobe counter: loaded on window entry, counts strobes down
    always_comb begin
        gate_d = gate_q;
        if (clr_s) begin
            gate_d = (gate_len == '0) ? GATE_W'(1) : gate_len;
        end else if (gate_open_s && clk_en) begin
            gate_d = gate_q - GATE_W'(1);
        end else begin
            gate_d = gate_q;
        end
    end

    // Result and lock qualification from the post-final-strobe counts
    always_comb begin
        delta_d     = $signed({1'b0, cnt_gen_nxt_s}) - $signed({1'b0, cnt_in_nxt_s});
        delta_mag_s = delta_d[DW-1] ? DW'(-delta_d) : DW'(delta_d);
        in_tol_s    = (delta_mag_s <= DW'(LOCK_TOL)) && !ovf_in_nxt_s && !ovf_gen_nxt_s;
        if (!in_tol_s) begin
            streak_d = '0;
        end else if (streak_q == STREAK_W'(LOCK_N)) begin
            streak_d = streak_q;
        end else begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // Sequencer state and gate counter registers
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            gate_q  <= '0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
        end
    end

    // Registered outputs; the result is captured on the edge into DONE
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            delta_q       <= '0;
            delta_valid_q <= 1'b0;
            ovf_q         <= 2'b00;
            streak_q      <= '0;
            lock_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            delta_valid_q <= done_fire_s;
            busy_q        <= (state_d != IDLE);
            if (done_fire_s) begin
                delta_q  <= delta_d;
                ovf_q    <= {ovf_gen_nxt_s, ovf_in_nxt_s};
                streak_q <= streak_d;
                lock_q   <= (streak_d == STREAK_W'(LOCK_N));
            end
        end
    end

    assign delta       = delta_q;
    assign delta_valid = delta_valid_q;
    assign ovf         = ovf_q;
    assign lock        = lock_q;
    assign busy        = busy_q;

endmodule

// File: doc/fll_freq_disc.md
# fll_freq_disc

Parametrised frequency discriminator for the frequency-locked loop in the SysFiltr datapath. It counts hysteresis-qualified positive zero crossings of the input signal and of the locally generated signal over a programmable gate window of sample strobes. At the end of each window it emits a signed count difference, overflow flags and a lock indication. The loop filter consumes `delta` on `delta_valid`; the NCO supplies `signal_gen`.

## Interface
- `DATA_W`, 32: sample width, signed.
- `CNT_W`, 24: crossing-counter width, unsigned, saturating.
- `GATE_W`, 32: width of `gate_len`.
- `HYST`, 100: Schmitt threshold magnitude, positive, same units as samples.
- `LOCK_TOL`, 2: maximum |delta| for a window to count as in-tolerance.
- `LOCK_N`, 4: consecutive in-tolerance windows required for lock, ≥1.

- `clk`  in  1  clock.
- `reset_l`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  sample strobe; samples and gate counting advance only when high.
- `start`  in  1  single-cycle request for one measurement window.
- `continuous`  in  1  when high, windows repeat back-to-back.
- `gate_len`  in  GATE_W  window length in strobes; 0 treated as 1; sampled at window start.
- `signal_input`  in  DATA_W  signed input samples.
- `signal_gen`  in  DATA_W  signed generator samples.
- `delta`  out  CNT_W+1  signed, count_gen − count_input; holds last result.
- `delta_valid`  out  1  one-cycle pulse when `delta` updates.
- `ovf`  out  2  {gen, input} counter saturated in the last window; updates with `delta`.
- `lock`  out  1  frequency lock indication.
- `busy`  out  1  high in GATE and DONE.

## Operation
- Crossing detector per channel, evaluated only on `clk_en`:
  - `neg` flag sets when sample ≤ −HYST.
  - A crossing event fires when `neg`=1 and sample ≥ +HYST; the same event clears `neg`.
  - Samples inside (−HYST, +HYST) change nothing.
  - Flags run in every state, so the phase carries across windows.
- Counters:
  - Clear on GATE entry.
  - Increment on a crossing event during GATE.
  - Saturate at 2^CNT_W−1; the per-channel ovf bit is set sticky for that window.
- FSM states IDLE, GATE, DONE:
  - IDLE → GATE on `start` or `continuous`. `gate_len` is latched on this transition.
  - GATE decrements a strobe counter on each `clk_en`. The crossing on the final strobe is counted. GATE → DONE after that strobe.
  - DONE lasts exactly one cycle: registers `delta` and `ovf`, pulses `delta_valid`, updates lock.
  - DONE → GATE if `continuous` is high; otherwise DONE → IDLE.
- `start` while busy is ignored and not queued.
- Deasserting `continuous` mid-window lets the current window finish, then the FSM goes to IDLE.
- Lock:
  - A streak counter increments on each result with |delta| ≤ LOCK_TOL, saturating at LOCK_N. Any other result clears it.
  - A window with any `ovf` bit set counts as out-of-tolerance.
  - `lock` = (streak == LOCK_N).
- Width rule: `delta` is the exact difference of two CNT_W unsigned values, so it never overflows.

## Timing
- Reset values:
  - FSM in IDLE.
  - `delta`=0, `delta_valid`=0, `ovf`=0, `lock`=0, `busy`=0.
  - Counters, streak counter and `neg` flags all cleared.
- Reset is asynchronous and takes effect mid-window; no partial result is emitted.
- `start` seen in IDLE at cycle t, with `clk_en` continuously high:
  - GATE occupies cycles t+1 … t+gate_len.
  - `delta_valid` is high at t+gate_len+1.
- Continuous mode:
  - The next GATE starts at t+gate_len+2.
  - A strobe during DONE is not gated: crossing events in that cycle are dropped, though the `neg` flags still update.
- `busy` is registered and is high exactly in GATE and DONE.

## Structure
- Package `fll_pkg`: state enum `fll_state_t` {IDLE, GATE, DONE}, and a `delta_w(CNT_W)` function returning CNT_W+1.
- Sub-module `zc_schmitt_cnt`: one crossing detector plus saturating counter with overflow flag. It is instantiated twice, for input and generator.
- The FSM, gate counter, delta subtractor and lock logic live in the top level.

## Test plan
- Periods: `clk_en`=1, gate_len=100, input ±1000 square period 10, gen ±1000 square period 20, `start` pulse → single `delta_valid` 101 cycles later with delta=−5, ovf=00.
- Hysteresis: input ±50 sine, HYST=100, gen period 10, gate_len=100 → count_input=0, delta=+10.
- Saturation: CNT_W=4, input period 4 over gate_len=100 (25 crossings) → count_input saturates at 15, ovf=01, and the window counts as out-of-tolerance for lock.
- Lock: LOCK_N=4, `continuous`=1, equal periods → `lock` rises with the 4th `delta_valid`. Then shift the gen period so |delta|=3 → `lock` falls at the next valid.
- Strobe gating: `clk_en` 1-in-3 with gate_len=10 → `delta_valid` 31 cycles after `start` (±2 depending on strobe phase). A `start` pulse mid-window is ignored.
- Reset mid-GATE, then `start` → no stale valid, fresh window result correct, all outputs read 0 during reset.
